lumi_crdt_sched: RTL and testbench
==================================

LUMI_CRDT_SCHED -- requirements
Module: lumi_crdt_sched

Interface
REQ-001 SHALL have parameter CRDTW, default 16, meaning credit counter width.
REQ-002 SHALL have parameter PCW, default 32, meaning performance counter width.
REQ-003 SHALL have port clk, input, 1, meaning the single clock for all logic.
REQ-004 SHALL have port reset, input, 1, meaning a synchronous, active-high reset.
REQ-005 SHALL have port csr_rxen, input, 1, meaning link receive enable.
REQ-006 SHALL have port csr_txcrdt_en, input, 1, meaning credit update enable.
REQ-007 SHALL have port csr_txcrdt_intrvl, input, 16, meaning update interval in cycles.
REQ-008 SHALL have ports csr_rxcrdt_req_init and csr_rxcrdt_resp_init, input, 16 each, meaning initial credits per channel.
REQ-009 SHALL have ports rx_req_pop and rx_resp_pop, input, 1 each, meaning one local rx fifo entry freed.
REQ-010 SHALL have ports crdt_valid (output, 1), crdt_data (output, 32, {resp,req} cumulative credits) and crdt_ready (input, 1), meaning the outgoing credit update handshake.
REQ-011 SHALL have ports rmt_crdt_valid (input, 1) and rmt_crdt_data (input, 32, {resp,req}), meaning a credit update received from the link partner.
REQ-012 SHALL have ports tx_req_valid and tx_resp_valid (input, 1 each) and tx_req_ok and tx_resp_ok (output, 1 each), meaning the tx credit request and grant per channel.
REQ-013 SHALL have ports csr_req_txcrdt_navail, csr_resp_txcrdt_navail, csr_req_txcrdt_avail and csr_resp_txcrdt_avail, output, PCW each, meaning stall and grant cycle counters.

Function
REQ-014 SHALL implement an FSM with states IDLE, INIT, WAIT and SEND.
REQ-015 SHALL move IDLE->INIT when csr_rxen & csr_txcrdt_en are both 1, and stay in IDLE otherwise.
REQ-016 SHALL, in INIT (one cycle), load the local counters loc_req/loc_resp and the tx limits lim_req/lim_resp from the *_init inputs, clear used_req/used_resp and all perf counters, then go to SEND.
REQ-017 SHALL increment loc_req on rx_req_pop and loc_resp on rx_resp_pop in every state except IDLE and INIT, wrapping modulo 2^CRDTW.
REQ-018 SHALL, on SEND entry, snapshot crdt_data={loc_resp,loc_req} and hold crdt_valid=1 with crdt_data stable until crdt_valid & crdt_ready.
REQ-019 SHALL, on the SEND handshake, store the snapshot as last-sent, clear the interval timer and go to WAIT.
REQ-020 SHALL, in WAIT, increment the timer each cycle; on timer==max(intrvl,1)-1, go to SEND if {loc_resp,loc_req}!=last-sent, else clear the timer and stay in WAIT.
REQ-021 SHALL count pops that occur during SEND into loc_* but not into the held crdt_data.
REQ-022 SHALL, on a disable (csr_rxen or csr_txcrdt_en low) in WAIT, go to IDLE next cycle.
REQ-023 SHALL, on a disable in SEND, complete the pending handshake and then go to IDLE, never deasserting crdt_valid before crdt_ready.
REQ-024 SHALL load lim_req and lim_resp from rmt_crdt_data on rmt_crdt_valid in any state except IDLE and INIT.
REQ-025 SHALL drive tx_req_ok=(lim_req-used_req)!=0 (CRDTW-bit modular subtraction) when the FSM is in WAIT or SEND, and 0 otherwise; tx_resp_ok likewise.
REQ-026 SHALL increment used_req when tx_req_valid & tx_req_ok (and likewise for resp); a same-cycle remote update and consume SHALL both take effect.
REQ-027 SHALL increment *_navail when tx_*_valid & ~tx_*_ok and *_avail when tx_*_valid & tx_*_ok, counting only outside IDLE and INIT and saturating at all-ones.

Reset
REQ-028 SHALL, on reset=1 at a clk edge, enter IDLE and zero all counters, timer, last-sent, crdt_valid, crdt_data, tx_*_ok and perf outputs.
REQ-029 SHALL apply REQ-028 even mid-handshake, with crdt_valid=0 in the cycle after reset is sampled.

Verification
REQ-030 SHALL cover: enable with req_init=8, resp_init=4 -> crdt_valid the 2nd cycle after IDLE exit with crdt_data=0x0004_0008.
REQ-031 SHALL cover: intrvl=16, 3 rx_req_pop, crdt_ready=1 -> the next update equals 0x0004_000B, 16 cycles after the previous handshake.
REQ-032 SHALL cover: crdt_ready held low 10 cycles with pops during that time -> crdt_data stays stable, and the pops appear in the following update.
REQ-033 SHALL cover: lim_req=2 and tx_req_valid held -> 2 grants, then tx_req_ok=0 and req_navail increments each cycle; rmt_crdt_data req=5 -> 3 more grants.
REQ-034 SHALL cover: lim-used wrap with used_req=0xFFFF and lim_req=0x0001 -> tx_req_ok=1 for exactly 2 grants.
REQ-035 SHALL cover: csr_txcrdt_en dropped while in SEND with crdt_ready=0 -> valid held until ready, then IDLE; reset asserted in SEND -> crdt_valid=0 the next cycle.

Source files
------------

// File: rtl/lumi_crdt_sched.sv
// lumi_crdt_sched
//   Link-level credit scheduler. Tracks credits freed by the local rx FIFOs
//   (loc_*), periodically advertises them to the link partner as cumulative
//   counts, and gates local tx traffic on the partner's advertised limits
//   (lim_*) against what has already been consumed (used_*).
//
// Ports
//   clk, reset                        single clock, synchronous active-high reset
//   csr_rxen, csr_txcrdt_en           both high to run the scheduler
//   csr_txcrdt_intrvl                 cycles between update checks (0 acts as 1)
//   csr_rxcrdt_req_init/_resp_init    initial credits per channel
//   rx_req_pop, rx_resp_pop           one local rx FIFO entry freed
//   crdt_valid/crdt_data/crdt_ready   outgoing update {resp,req}
//   rmt_crdt_valid/rmt_crdt_data      partner update {resp,req} -> tx limits
//   tx_*_valid / tx_*_ok              tx credit request / grant per channel
//   csr_*_txcrdt_navail/_avail        saturating stall / grant cycle counters
module lumi_crdt_sched #(
  parameter int unsigned CRDTW = 16,
  parameter int unsigned PCW   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               csr_rxen,
  input  logic               csr_txcrdt_en,
  input  logic [15:0]        csr_txcrdt_intrvl,
  input  logic [CRDTW-1:0]   csr_rxcrdt_req_init,
  input  logic [CRDTW-1:0]   csr_rxcrdt_resp_init,
  input  logic               rx_req_pop,
  input  logic               rx_resp_pop,
  output logic               crdt_valid,
  output logic [2*CRDTW-1:0] crdt_data,
  input  logic               crdt_ready,
  input  logic               rmt_crdt_valid,
  input  logic [2*CRDTW-1:0] rmt_crdt_data,
  input  logic               tx_req_valid,
  input  logic               tx_resp_valid,
  output logic               tx_req_ok,
  output logic               tx_resp_ok,
  output logic [PCW-1:0]     csr_req_txcrdt_navail,
  output logic [PCW-1:0]     csr_resp_txcrdt_navail,
  output logic [PCW-1:0]     csr_req_txcrdt_avail,
  output logic [PCW-1:0]     csr_resp_txcrdt_avail
);

  typedef enum logic [1:0] {IDLE, INIT, WAIT, SEND} state_e;

  state_e             state_q;
  logic [15:0]        timer_q;
  logic [2*CRDTW-1:0] last_q;
  logic               crdt_valid_q;
  logic [2*CRDTW-1:0] crdt_data_q;

  logic [CRDTW-1:0] loc_req_q, loc_req_d, loc_resp_q, loc_resp_d;
  logic [CRDTW-1:0] lim_req_q, lim_req_d, lim_resp_q, lim_resp_d;
  logic [CRDTW-1:0] used_req_q, used_req_d, used_resp_q, used_resp_d;
  logic [PCW-1:0]   req_navail_q, req_navail_d, resp_navail_q, resp_navail_d;
  logic [PCW-1:0]   req_avail_q, req_avail_d, resp_avail_q, resp_avail_d;

  logic               enable;
  logic               active;
  logic [15:0]        intrvl_m1;
  logic [2*CRDTW-1:0] loc_cat;
  logic [CRDTW-1:0]   req_room, resp_room;

  assign enable    = csr_rxen & csr_txcrdt_en;
  assign active    = (state_q == WAIT) || (state_q == SEND);
  assign intrvl_m1 = (csr_txcrdt_intrvl == '0) ? '0 : csr_txcrdt_intrvl - 16'd1;
  assign loc_cat   = {loc_resp_q, loc_req_q};

  // Room is modular so a used counter that wrapped past the limit still
  // yields the right number of grants.
  assign req_room   = lim_req_q - used_req_q;
  assign resp_room  = lim_resp_q - used_resp_q;
  assign tx_req_ok  = active && (req_room != '0);
  assign tx_resp_ok = active && (resp_room != '0);

  function automatic logic [PCW-1:0] sat_inc(input logic [PCW-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + PCW'(1) : v;
  endfunction

  // Update FSM. crdt_data is snapshotted on SEND entry and held until the
  // handshake; a disable in SEND only takes effect once the handshake is done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      last_q       <= '0;
      crdt_valid_q <= 1'b0;
      crdt_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) state_q <= INIT;
        end
        INIT: begin
          state_q      <= SEND;
          crdt_valid_q <= 1'b1;
          crdt_data_q  <= {csr_rxcrdt_resp_init, csr_rxcrdt_req_init};
        end
        WAIT: begin
          if (!enable) begin
            state_q <= IDLE;
          end else if (timer_q == intrvl_m1) begin
            if (loc_cat != last_q) begin
              state_q      <= SEND;
              crdt_valid_q <= 1'b1;
              crdt_data_q  <= loc_cat;
            end else begin
              timer_q <= '0;
            end
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        SEND: begin
          if (crdt_valid_q && crdt_ready) begin
            crdt_valid_q <= 1'b0;
            last_q       <= crdt_data_q;
            timer_q      <= '0;
            state_q      <= enable ? WAIT : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign crdt_valid = crdt_valid_q;
  assign crdt_data  = crdt_data_q;

  always_comb begin
    loc_req_d     = loc_req_q;
    loc_resp_d    = loc_resp_q;
    lim_req_d     = lim_req_q;
    lim_resp_d    = lim_resp_q;
    used_req_d    = used_req_q;
    used_resp_d   = used_resp_q;
    req_navail_d  = req_navail_q;
    resp_navail_d = resp_navail_q;
    req_avail_d   = req_avail_q;
    resp_avail_d  = resp_avail_q;
    if (state_q == INIT) begin
      loc_req_d     = csr_rxcrdt_req_init;
      loc_resp_d    = csr_rxcrdt_resp_init;
      lim_req_d     = csr_rxcrdt_req_init;
      lim_resp_d    = csr_rxcrdt_resp_init;
      used_req_d    = '0;
      used_resp_d   = '0;
      req_navail_d  = '0;
      resp_navail_d = '0;
      req_avail_d   = '0;
      resp_avail_d  = '0;
    end else if (active) begin
      if (rx_req_pop)  loc_req_d  = loc_req_q + CRDTW'(1);
      if (rx_resp_pop) loc_resp_d = loc_resp_q + CRDTW'(1);
      // Limit reload and consumption touch separate registers, so a
      // same-cycle remote update and grant both land.
      if (rmt_crdt_valid) begin
        lim_req_d  = rmt_crdt_data[CRDTW-1:0];
        lim_resp_d = rmt_crdt_data[2*CRDTW-1:CRDTW];
      end
      if (tx_req_valid && tx_req_ok)   used_req_d  = used_req_q + CRDTW'(1);
      if (tx_resp_valid && tx_resp_ok) used_resp_d = used_resp_q + CRDTW'(1);
      req_navail_d  = sat_inc(req_navail_q,  tx_req_valid  && !tx_req_ok);
      resp_navail_d = sat_inc(resp_navail_q, tx_resp_valid && !tx_resp_ok);
      req_avail_d   = sat_inc(req_avail_q,   tx_req_valid  && tx_req_ok);
      resp_avail_d  = sat_inc(resp_avail_q,  tx_resp_valid && tx_resp_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      loc_req_q     <= '0;
      loc_resp_q    <= '0;
      lim_req_q     <= '0;
      lim_resp_q    <= '0;
      used_req_q    <= '0;
      used_resp_q   <= '0;
      req_navail_q  <= '0;
      resp_navail_q <= '0;
      req_avail_q   <= '0;
      resp_avail_q  <= '0;
    end else begin
      loc_req_q     <= loc_req_d;
      loc_resp_q    <= loc_resp_d;
      lim_req_q     <= lim_req_d;
      lim_resp_q    <= lim_resp_d;
      used_req_q    <= used_req_d;
      used_resp_q   <= used_resp_d;
      req_navail_q  <= req_navail_d;
      resp_navail_q <= resp_navail_d;
      req_avail_q   <= req_avail_d;
      resp_avail_q  <= resp_avail_d;
    end
  end

  assign csr_req_txcrdt_navail  = req_navail_q;
  assign csr_resp_txcrdt_navail = resp_navail_q;
  assign csr_req_txcrdt_avail   = req_avail_q;
  assign csr_resp_txcrdt_avail  = resp_avail_q;

endmodule

// File: tb/tb_lumi_crdt_sched.sv
// tb_lumi_crdt_sched
//   Directed bench for lumi_crdt_sched: expected credit updates are queued
//   when the stimulus that defines them is applied and popped when the DUT
//   presents the update; grant/stall behaviour is checked cycle by cycle.
module tb_lumi_crdt_sched;

  logic        clk;
  logic        reset;
  logic        csr_rxen;
  logic        csr_txcrdt_en;
  logic [15:0] csr_txcrdt_intrvl;
  logic [15:0] csr_rxcrdt_req_init;
  logic [15:0] csr_rxcrdt_resp_init;
  logic        rx_req_pop;
  logic        rx_resp_pop;
  logic        crdt_valid;
  logic [31:0] crdt_data;
  logic        crdt_ready;
  logic        rmt_crdt_valid;
  logic [31:0] rmt_crdt_data;
  logic        tx_req_valid;
  logic        tx_resp_valid;
  logic        tx_req_ok;
  logic        tx_resp_ok;
  logic [31:0] csr_req_txcrdt_navail;
  logic [31:0] csr_resp_txcrdt_navail;
  logic [31:0] csr_req_txcrdt_avail;
  logic [31:0] csr_resp_txcrdt_avail;

  lumi_crdt_sched #(.CRDTW(16), .PCW(32)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .csr_rxen               (csr_rxen),
    .csr_txcrdt_en          (csr_txcrdt_en),
    .csr_txcrdt_intrvl      (csr_txcrdt_intrvl),
    .csr_rxcrdt_req_init    (csr_rxcrdt_req_init),
    .csr_rxcrdt_resp_init   (csr_rxcrdt_resp_init),
    .rx_req_pop             (rx_req_pop),
    .rx_resp_pop            (rx_resp_pop),
    .crdt_valid             (crdt_valid),
    .crdt_data              (crdt_data),
    .crdt_ready             (crdt_ready),
    .rmt_crdt_valid         (rmt_crdt_valid),
    .rmt_crdt_data          (rmt_crdt_data),
    .tx_req_valid           (tx_req_valid),
    .tx_resp_valid          (tx_resp_valid),
    .tx_req_ok              (tx_req_ok),
    .tx_resp_ok             (tx_resp_ok),
    .csr_req_txcrdt_navail  (csr_req_txcrdt_navail),
    .csr_resp_txcrdt_navail (csr_resp_txcrdt_navail),
    .csr_req_txcrdt_avail   (csr_req_txcrdt_avail),
    .csr_resp_txcrdt_avail  (csr_resp_txcrdt_avail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_pass  = 0;
  int          n_fail  = 0;
  int          n;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_upd(input string tag);
    logic [31:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    chk(tag, 64'(crdt_data), 64'(e));
  endtask

  // Outputs are sampled 1 time unit after the active edge; inputs changed
  // here are seen by the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int limit);
    n = 0;
    while (!crdt_valid && n < limit) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    reset                = 1'b1;
    csr_rxen             = 1'b0;
    csr_txcrdt_en        = 1'b0;
    csr_txcrdt_intrvl    = 16'd16;
    csr_rxcrdt_req_init  = 16'd8;
    csr_rxcrdt_resp_init = 16'd4;
    rx_req_pop           = 1'b0;
    rx_resp_pop          = 1'b0;
    crdt_ready           = 1'b0;
    rmt_crdt_valid       = 1'b0;
    rmt_crdt_data        = '0;
    tx_req_valid         = 1'b0;
    tx_resp_valid        = 1'b0;

    tick();
    tick();
    chk("rst_valid",       64'(crdt_valid), 64'(0));
    chk("rst_data",        64'(crdt_data), 64'(0));
    chk("rst_req_ok",      64'(tx_req_ok), 64'(0));
    chk("rst_resp_ok",     64'(tx_resp_ok), 64'(0));
    chk("rst_req_avail",   64'(csr_req_txcrdt_avail), 64'(0));
    chk("rst_req_navail",  64'(csr_req_txcrdt_navail), 64'(0));
    chk("rst_resp_avail",  64'(csr_resp_txcrdt_avail), 64'(0));
    chk("rst_resp_navail", 64'(csr_resp_txcrdt_navail), 64'(0));
    reset = 1'b0;
    tick();
    chk("idle_valid", 64'(crdt_valid), 64'(0));

    // Enable: INIT for one cycle, then SEND with the init credits.
    exp_q.push_back(32'h0004_0008);
    csr_rxen      = 1'b1;
    csr_txcrdt_en = 1'b1;
    tick();
    chk("init_valid", 64'(crdt_valid), 64'(0));
    tick();
    chk("first_valid", 64'(crdt_valid), 64'(1));
    chk_upd("first_data");
    chk("send_req_ok", 64'(tx_req_ok), 64'(1));

    // Handshake, then three req pops; next update lands 16 cycles later.
    crdt_ready = 1'b1;
    tick();
    chk("hs_valid_low", 64'(crdt_valid), 64'(0));
    exp_q.push_back(32'h0004_000B);
    n = 0;
    rx_req_pop = 1'b1;
    repeat (3) begin
      tick();
      n++;
    end
    rx_req_pop = 1'b0;
    while (!crdt_valid && n < 40) begin
      tick();
      n++;
    end
    crdt_ready = 1'b0;
    chk("intrvl_gap", 64'(n), 64'(16));
    chk_upd("upd_3pops");

    // Back-pressure with pops during SEND: held data must not move.
    for (int i = 0; i < 10; i++) begin
      rx_resp_pop = (i < 2);
      rx_req_pop  = (i == 5);
      tick();
      chk("hold_valid", 64'(crdt_valid), 64'(1));
      chk("hold_data", 64'(crdt_data), 64'(32'h0004_000B));
    end
    rx_resp_pop = 1'b0;
    rx_req_pop  = 1'b0;
    exp_q.push_back(32'h0006_000C);
    crdt_ready = 1'b1;
    tick();
    chk("hold_hs_low", 64'(crdt_valid), 64'(0));
    wait_valid(40);
    chk("intrvl_gap2", 64'(n), 64'(16));
    chk_upd("upd_held_pops");
    tick();
    chk("hs2_valid_low", 64'(crdt_valid), 64'(0));
    crdt_ready = 1'b0;

    // Remote limit of 2: two grants, then stalls, then limit 5 gives three more.
    rmt_crdt_valid = 1'b1;
    rmt_crdt_data  = 32'h0004_0002;
    tick();
    rmt_crdt_valid = 1'b0;
    chk("lim2_ok", 64'(tx_req_ok), 64'(1));
    chk("lim2_resp_ok", 64'(tx_resp_ok), 64'(1));
    chk("avail_start", 64'(csr_req_txcrdt_avail), 64'(0));
    tx_req_valid = 1'b1;
    tick();
    chk("grant1_ok", 64'(tx_req_ok), 64'(1));
    tick();
    chk("grant2_ok", 64'(tx_req_ok), 64'(0));
    chk("avail2", 64'(csr_req_txcrdt_avail), 64'(2));
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("stall_ok", 64'(tx_req_ok), 64'(0));
      chk("navail_inc", 64'(csr_req_txcrdt_navail), 64'(i));
    end
    rmt_crdt_valid = 1'b1;
    rmt_crdt_data  = 32'h0004_0005;
    tick();
    rmt_crdt_valid = 1'b0;
    chk("lim5_ok", 64'(tx_req_ok), 64'(1));
    chk("navail4", 64'(csr_req_txcrdt_navail), 64'(4));
    tick();
    chk("lim5_g1", 64'(tx_req_ok), 64'(1));
    tick();
    chk("lim5_g2", 64'(tx_req_ok), 64'(1));
    tick();
    chk("lim5_g3_end", 64'(tx_req_ok), 64'(0));
    chk("avail5", 64'(csr_req_txcrdt_avail), 64'(5));

    // Drive used_req up to 0xFFFF, then limit 1: modular room of 2.
    rmt_crdt_valid = 1'b1;
    rmt_crdt_data  = 32'h0004_FFFF;
    tick();
    rmt_crdt_valid = 1'b0;
    n = 0;
    while (tx_req_ok && n < 70000) begin
      tick();
      n++;
    end
    chk("wrap_fill", 64'(n), 64'(65530));
    chk("wrap_full_ok", 64'(tx_req_ok), 64'(0));
    rmt_crdt_valid = 1'b1;
    rmt_crdt_data  = 32'h0004_0001;
    tick();
    rmt_crdt_valid = 1'b0;
    chk("wrap_ok1", 64'(tx_req_ok), 64'(1));
    tick();
    chk("wrap_ok2", 64'(tx_req_ok), 64'(1));
    tick();
    chk("wrap_ok_end", 64'(tx_req_ok), 64'(0));
    tx_req_valid = 1'b0;
    chk("avail_total", 64'(csr_req_txcrdt_avail), 64'(65537));
    chk("navail_total", 64'(csr_req_txcrdt_navail), 64'(6));
    chk("resp_avail_idle", 64'(csr_resp_txcrdt_avail), 64'(0));

    // Disable while SEND is back-pressured: valid holds until ready.
    rx_req_pop = 1'b1;
    tick();
    rx_req_pop = 1'b0;
    exp_q.push_back(32'h0006_000D);
    wait_valid(40);
    chk("send_again", 64'(crdt_valid), 64'(1));
    chk_upd("upd_pre_disable");
    csr_txcrdt_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dis_hold_valid", 64'(crdt_valid), 64'(1));
      chk("dis_hold_data", 64'(crdt_data), 64'(32'h0006_000D));
    end
    crdt_ready = 1'b1;
    tick();
    crdt_ready = 1'b0;
    chk("dis_done_valid", 64'(crdt_valid), 64'(0));
    chk("dis_idle_resp_ok", 64'(tx_resp_ok), 64'(0));
    tick();
    chk("dis_stay_idle", 64'(crdt_valid), 64'(0));

    // Re-enable reloads init credits; reset during SEND drops valid at once.
    exp_q.push_back(32'h0004_0008);
    csr_txcrdt_en = 1'b1;
    tick();
    tick();
    chk("reinit_valid", 64'(crdt_valid), 64'(1));
    chk_upd("reinit_data");
    chk("reinit_avail_clr", 64'(csr_req_txcrdt_avail), 64'(0));
    reset = 1'b1;
    tick();
    chk("rst_send_valid", 64'(crdt_valid), 64'(0));
    chk("rst_send_data", 64'(crdt_data), 64'(0));
    chk("rst_send_resp_ok", 64'(tx_resp_ok), 64'(0));
    reset         = 1'b0;
    csr_rxen      = 1'b0;
    csr_txcrdt_en = 1'b0;
    tick();
    chk("post_rst_idle", 64'(crdt_valid), 64'(0));
    chk("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
